// File: rtl/aes_round_sequencer.sv
// AES-128 round sequencer: steps one block through a shared req/ack ALU and reports the ciphertext.
// Define AES_SEQ_TIMEOUT_EN to add the stalled-ALU watchdog that drives error_o.
module aes_round_sequencer #(
  parameter int unsigned ROUNDS = 10
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic [127:0] plaintext_i,
  input  logic [127:0] round_key_i,
  output logic [3:0]   key_idx_o,
  output logic         alu_req_o,
  output logic [3:0]   alu_op_o,
  output logic [127:0] alu_state_o,
  output logic [127:0] alu_key_o,
  input  logic         alu_ack_i,
  input  logic [127:0] alu_result_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [127:0] ciphertext_o,
  output logic         error_o
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StInit  = 3'd1;
  localparam logic [2:0] StSub   = 3'd2;
  localparam logic [2:0] StShift = 3'd3;
  localparam logic [2:0] StMix   = 3'd4;
  localparam logic [2:0] StArk   = 3'd5;
  localparam logic [2:0] StDone  = 3'd6;

  localparam logic [3:0] OpSub   = 4'b0001;
  localparam logic [3:0] OpShift = 4'b0010;
  localparam logic [3:0] OpMix   = 4'b0100;
  localparam logic [3:0] OpArk   = 4'b1000;

  localparam logic [3:0] LastRound = 4'(ROUNDS);

  logic [2:0]   state_q, state_d;
  logic [3:0]   key_idx_q, key_idx_d;
  logic [127:0] data_q, data_d;
  logic [127:0] ct_q, ct_d;
  logic         alu_req;
  logic         abort;

  always_comb begin
    alu_req  = 1'b0;
    alu_op_o = 4'b0000;
    case (state_q)
      StInit:  begin alu_req = 1'b1; alu_op_o = OpArk;   end
      StSub:   begin alu_req = 1'b1; alu_op_o = OpSub;   end
      StShift: begin alu_req = 1'b1; alu_op_o = OpShift; end
      StMix:   begin alu_req = 1'b1; alu_op_o = OpMix;   end
      StArk:   begin alu_req = 1'b1; alu_op_o = OpArk;   end
      default: begin alu_req = 1'b0; alu_op_o = 4'b0000; end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    key_idx_d = key_idx_q;
    data_d    = data_q;
    ct_d      = ct_q;
    // Every accepted result replaces the state; only IDLE loads from elsewhere.
    if (alu_req && alu_ack_i) begin
      data_d = alu_result_i;
    end
    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d   = StInit;
          data_d    = plaintext_i;
          key_idx_d = 4'd0;
        end
      end
      StInit: begin
        if (alu_ack_i) begin
          state_d   = StSub;
          key_idx_d = 4'd1;
        end
      end
      StSub: begin
        if (alu_ack_i) state_d = StShift;
      end
      StShift: begin
        if (alu_ack_i) state_d = (key_idx_q == LastRound) ? StArk : StMix;
      end
      StMix: begin
        if (alu_ack_i) state_d = StArk;
      end
      StArk: begin
        if (alu_ack_i) begin
          if (key_idx_q == LastRound) begin
            state_d = StDone;
            ct_d    = alu_result_i;
          end else begin
            state_d   = StSub;
            key_idx_d = key_idx_q + 4'd1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (abort) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      key_idx_q <= 4'd0;
      data_q    <= '0;
      ct_q      <= '0;
    end else begin
      state_q   <= state_d;
      key_idx_q <= key_idx_d;
      data_q    <= data_d;
      ct_q      <= ct_d;
    end
  end

`ifdef AES_SEQ_TIMEOUT_EN
  logic [4:0] wd_q, wd_d;
  logic       err_q, err_d;

  // Counter stays at zero outside a stalled request, so each new phase starts clean.
  assign abort = alu_req && !alu_ack_i && (wd_q == 5'd15);

  always_comb begin
    wd_d  = (alu_req && !alu_ack_i) ? wd_q + 5'd1 : 5'd0;
    err_d = err_q;
    if (abort) begin
      err_d = 1'b1;
    end else if (state_q == StIdle && start_i) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wd_q  <= 5'd0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign error_o = err_q;
`else
  assign abort   = 1'b0;
  assign error_o = 1'b0;
`endif

  assign key_idx_o    = key_idx_q;
  assign alu_req_o    = alu_req;
  assign alu_state_o  = data_q;
  assign alu_key_o    = (alu_op_o == OpArk) ? round_key_i : '0;
  assign busy_o       = (state_q != StIdle);
  assign done_o       = (state_q == StDone);
  assign ciphertext_o = ct_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: AES ALU and key-schedule models, op-trace and ciphertext scoreboard.
// The watchdog scenario is built only when AES_SEQ_TIMEOUT_EN is defined.
module tb_aes_round_sequencer;

  localparam logic [3:0] OpSub   = 4'b0001;
  localparam logic [3:0] OpShift = 4'b0010;
  localparam logic [3:0] OpMix   = 4'b0100;
  localparam logic [3:0] OpArk   = 4'b1000;

  localparam logic [127:0] FipsKey = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FipsPt  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] FipsCt  = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0;
  logic         reset, start, alu_req, alu_ack, busy, done, error;
  logic [3:0]   key_idx, alu_op;
  logic [127:0] plaintext, round_key, alu_state, alu_key, alu_result, ciphertext;

  int unsigned  n_checks = 0, n_fail = 0;
  int unsigned  cyc = 0, start_cyc = 0, wait_total = 0, max_wait = 0, done_cnt = 0;
  bit           stall_en = 1'b0, trace_en = 1'b1;
  logic [7:0]   sbox_t [256];
  logic [127:0] rk_t [16];
  logic [7:0]   exp_op_q [$];
  logic [127:0] exp_ct_q [$];

  aes_round_sequencer #(.ROUNDS(10)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .start_i      (start),
    .plaintext_i  (plaintext),
    .round_key_i  (round_key),
    .key_idx_o    (key_idx),
    .alu_req_o    (alu_req),
    .alu_op_o     (alu_op),
    .alu_state_o  (alu_state),
    .alu_key_o    (alu_key),
    .alu_ack_i    (alu_ack),
    .alu_result_i (alu_result),
    .busy_o       (busy),
    .done_o       (done),
    .ciphertext_o (ciphertext),
    .error_o      (error)
  );

  always #5 clk = ~clk;

  always_comb round_key = rk_t[key_idx];

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box from first principles: x^254 inverse followed by the affine map.
  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] r = 8'h01;
    logic [7:0] b = x;
    logic [7:0] s;
    for (int e = 254; e > 0; e = e >> 1) begin
      if (e[0]) r = gf_mul(r, b);
      b = gf_mul(b, b);
    end
    s = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox_t[s[127-8*i -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++)
        r[127-8*(rw+4*c) -: 8] = s[127-8*(rw+4*((c+rw)%4)) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  function automatic logic [127:0] alu_model(input logic [3:0] op, input logic [127:0] st,
                                             input logic [127:0] k);
    case (op)
      OpSub:   return sub_bytes(st);
      OpShift: return shift_rows(st);
      OpMix:   return mix_cols(st);
      OpArk:   return st ^ k;
      default: return ~st;
    endcase
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt);
    logic [127:0] s = pt ^ rk_t[0];
    for (int r = 1; r <= 10; r++) begin
      s = shift_rows(sub_bytes(s));
      if (r != 10) s = mix_cols(s);
      s = s ^ rk_t[r];
    end
    return s;
  endfunction

  task automatic push_trace();
    exp_op_q.push_back({4'd0, OpArk});
    for (int r = 1; r <= 10; r++) begin
      exp_op_q.push_back({4'(r), OpSub});
      exp_op_q.push_back({4'(r), OpShift});
      if (r != 10) exp_op_q.push_back({4'(r), OpMix});
      exp_op_q.push_back({4'(r), OpArk});
    end
  endtask

  task automatic encrypt(input logic [127:0] pt, input logic [127:0] exp_ct,
                         input int unsigned mw, input bit pulse);
    int unsigned d0;
    bit got;
    max_wait = mw;
    push_trace();
    exp_ct_q.push_back(exp_ct);
    @(negedge clk);
    wait_total = 0;
    start      = 1'b1;
    plaintext  = pt;
    start_cyc  = cyc;
    d0         = done_cnt;
    @(negedge clk);
    start     = 1'b0;
    plaintext = '0;
    check_eq("busy_after_start", busy, 1'b1);
    check_eq("error_clear", error, 1'b0);
    got = 1'b0;
    for (int i = 1; i <= 1000; i++) begin
      // Starts during an encryption must be ignored, even with a different block.
      if (pulse && (i == 5 || i == 20)) begin
        start     = 1'b1;
        plaintext = ~pt;
      end else begin
        start     = 1'b0;
        plaintext = '0;
      end
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    start = 1'b0;
    check_eq("done_seen", got, 1'b1);
    repeat (3) @(negedge clk);
    check_eq("done_count", done_cnt - d0, 1);
    check_eq("ct_held", ciphertext, exp_ct);
    check_eq("idle_busy", busy, 1'b0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ALU model with random wait states, plus trace, stability and completion checks.
  initial begin
    logic [3:0]   h_op;
    logic [127:0] h_st, h_key;
    logic [7:0]   e;
    bit           hold, in_ph;
    int unsigned  wl;
    hold = 1'b0; in_ph = 1'b0; wl = 0;
    alu_ack = 1'b0; alu_result = '0;
    h_op = '0; h_st = '0; h_key = '0;
    forever begin
      @(negedge clk);
      if (hold && alu_req) begin
        check_eq("stable_op", alu_op, h_op);
        check_eq("stable_state", alu_state, h_st);
        check_eq("stable_key", alu_key, h_key);
      end
      if (alu_req) begin
        if (!in_ph) begin
          wl    = (max_wait == 0) ? 0 : $urandom_range(max_wait, 0);
          in_ph = 1'b1;
        end
        if (wl == 0 && !(stall_en && alu_op == OpShift && key_idx == 4'd3)) begin
          alu_ack = 1'b1;
          in_ph   = 1'b0;
        end else begin
          alu_ack = 1'b0;
          if (wl > 0) wl--;
          wait_total++;
        end
      end else begin
        in_ph   = 1'b0;
        alu_ack = 1'($urandom_range(1, 0));
      end
      alu_result = alu_model(alu_op, alu_state, alu_key);
      hold  = alu_req && !alu_ack;
      h_op  = alu_op;
      h_st  = alu_state;
      h_key = alu_key;
      if (alu_req && alu_ack && trace_en) begin
        if (exp_op_q.size() == 0) begin
          check_eq("extra_op", alu_op, 4'b0000);
        end else begin
          e = exp_op_q.pop_front();
          check_eq("op", alu_op, e[3:0]);
          check_eq("op_key_idx", key_idx, e[7:4]);
          check_eq("alu_key", alu_key, (e[3:0] == OpArk) ? rk_t[e[7:4]] : '0);
        end
      end
      if (done) begin
        done_cnt++;
        if (exp_ct_q.size() == 0) begin
          check_eq("unexp_done", done, 1'b0);
        end else begin
          check_eq("ciphertext", ciphertext, exp_ct_q.pop_front());
          check_eq("latency", cyc - start_cyc, 41 + wait_total);
          check_eq("ops_left", exp_op_q.size(), 0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

  initial begin
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [127:0] pt, ref_ct;
    int unsigned  d0;
    for (int i = 0; i < 256; i++) sbox_t[i] = sbox_calc(8'(i));
    for (int i = 0; i < 16; i++) rk_t[i] = '0;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = FipsKey[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) rk_t[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};

    reset = 1'b1; start = 1'b0; plaintext = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_req", alu_req, 1'b0);
    check_eq("rst_op", alu_op, 4'b0000);
    check_eq("rst_key_idx", key_idx, 4'd0);
    check_eq("rst_state", alu_state, '0);
    check_eq("rst_key", alu_key, '0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_ct", ciphertext, '0);
    check_eq("rst_error", error, 1'b0);
    reset = 1'b0;

    encrypt(FipsPt, FipsCt, 0, 1'b0);
    encrypt(FipsPt, FipsCt, 5, 1'b0);
    encrypt(FipsPt, FipsCt, 0, 1'b1);

    // Reset while op 17 is being acknowledged.
    max_wait = 0;
    push_trace();
    @(negedge clk);
    start = 1'b1; plaintext = FipsPt;
    @(negedge clk);
    start = 1'b0; plaintext = '0;
    repeat (16) @(negedge clk);
    d0 = done_cnt;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("mid_rst_busy", busy, 1'b0);
    check_eq("mid_rst_req", alu_req, 1'b0);
    check_eq("mid_rst_key_idx", key_idx, 4'd0);
    check_eq("mid_rst_done", done, 1'b0);
    check_eq("mid_rst_ct", ciphertext, '0);
    exp_op_q.delete();
    repeat (50) @(negedge clk);
    check_eq("mid_rst_no_done", done_cnt - d0, 0);
    encrypt(FipsPt, FipsCt, 3, 1'b0);

    pt     = {$urandom, $urandom, $urandom, $urandom};
    ref_ct = aes_ref(pt);
    encrypt(pt, ref_ct, 5, 1'b0);

`ifdef AES_SEQ_TIMEOUT_EN
    begin : wd_test
      bit seen;
      trace_en = 1'b0; stall_en = 1'b1; max_wait = 0;
      d0 = done_cnt;
      @(negedge clk);
      start = 1'b1; plaintext = FipsPt;
      @(negedge clk);
      start = 1'b0; plaintext = '0;
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
        if (alu_req && alu_op == OpShift && key_idx == 4'd3) begin
          seen = 1'b1;
          break;
        end
        @(negedge clk);
      end
      check_eq("stall_reached", seen, 1'b1);
      repeat (15) @(negedge clk);
      check_eq("wd_still_busy", busy, 1'b1);
      check_eq("wd_no_error_yet", error, 1'b0);
      @(negedge clk);
      check_eq("wd_error", error, 1'b1);
      check_eq("wd_busy", busy, 1'b0);
      check_eq("wd_req", alu_req, 1'b0);
      check_eq("wd_ct_kept", ciphertext, ref_ct);
      repeat (3) @(negedge clk);
      check_eq("wd_error_held", error, 1'b1);
      check_eq("wd_no_done", done_cnt - d0, 0);
      stall_en = 1'b0; trace_en = 1'b1;
      encrypt(FipsPt, FipsCt, 0, 1'b0);
    end
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
